// File: rtl/clkdiv_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding and the
// phase-counter saturation value.
package clkdiv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } mon_state_t;

    // All-ones value of a w-bit counter, i.e. {w{1'b1}}.
    function automatic logic [63:0] cnt_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level with registered-delay
// edge detection on the synchronized output.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= {SYNC_STAGES{RST_VAL}};
            s_d     <= RST_VAL;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
            s_d     <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign s    = sync_p0[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures high/low time and period of a divided clock sampled in the clk
// domain, checks the period against a tolerance and reports lock/err/timeout.
module clkdiv_monitor
    import clkdiv_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_N      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic [CNT_W:0]   exp_period,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             err,
    output logic             lock,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));
    localparam int               GC_W    = $clog2(LOCK_N + 1);
    localparam logic [GC_W-1:0]  GC_MAX  = GC_W'(LOCK_N);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [GC_W-1:0] sat_inc_gc(input logic [GC_W-1:0] v);
        return (v == GC_MAX) ? v : v + GC_W'(1);
    endfunction

    // Signed difference is one bit wider than the period so |p - e| cannot wrap.
    function automatic logic in_tol(input logic [CNT_W:0]   p,
                                    input logic [CNT_W:0]   e,
                                    input logic [CNT_W-1:0] t);
        logic signed [CNT_W+1:0] diff;
        logic signed [CNT_W+1:0] mag;
        diff = $signed({1'b0, p}) - $signed({1'b0, e});
        mag  = (diff < 0) ? -diff : diff;
        return mag <= $signed({2'b00, t});
    endfunction

    logic             s_unused;
    logic             rise;
    logic             fall;
    logic             edge_seen;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt;
    mon_state_t       st;
    mon_state_t       st_nxt;
    logic [GC_W-1:0]  gc;
    logic [GC_W-1:0]  gc_nxt;
    logic             latch_high;
    logic             meas_done;
    logic             chk_en;
    logic             good;
    logic [CNT_W:0]   period_nxt;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .d     (div_in),
        .s     (s_unused),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_seen = rise | fall;
    assign tmo_hit   = (cnt == CNT_SAT) && !edge_seen;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (edge_seen || tmo_hit)
            cnt <= CNT_W'(1);
        else
            cnt <= sat_inc_cnt(cnt);
    end

    always_ff @(posedge clk) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (tmo_hit) begin
            st_nxt = IDLE;
        end else begin
            unique case (st)
                IDLE:    if (rise) st_nxt = HIGH;
                HIGH:    if (fall) st_nxt = LOW;
                LOW:     if (rise) st_nxt = HIGH;
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        latch_high = 1'b0;
        meas_done  = 1'b0;
        period_nxt = {1'b0, high_cnt} + {1'b0, cnt};
        chk_en     = (exp_period != '0);
        good       = chk_en && in_tol(period_nxt, exp_period, tol);
        gc_nxt     = gc;
        if (tmo_hit) begin
            gc_nxt = '0;
        end else begin
            latch_high = (st == HIGH) && fall;
            meas_done  = (st == LOW) && rise;
            if (meas_done)
                gc_nxt = good ? sat_inc_gc(gc) : '0;
        end
    end

    // Registered results: one cycle after the edge is seen in the sync domain
    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            err        <= 1'b0;
            lock       <= 1'b0;
            timeout    <= 1'b0;
            gc         <= '0;
        end else begin
            meas_valid <= meas_done;
            err        <= meas_done && chk_en && !good;
            timeout    <= tmo_hit;
            gc         <= gc_nxt;
            lock       <= (gc_nxt == GC_MAX);
            if (latch_high)
                high_cnt <= cnt;
            if (meas_done) begin
                low_cnt <= cnt;
                period  <= period_nxt;
            end
        end
    end

endmodule
